// File: rtl/l1b_cache_pkg.sv
// rtl/l1b_cache_pkg.sv - shared types and helpers for the L1 buffer read-return path
package l1b_cache_pkg;

  localparam int L1B_ONE_BANK_NUM = 8;
  localparam int L1B_SLOT_WID     = $clog2(L1B_ONE_BANK_NUM);

  typedef struct packed {
    logic                    vld;
    logic [1:0]              bank_vld;
    logic [L1B_SLOT_WID-1:0] slot0;
    logic [L1B_SLOT_WID-1:0] slot1;
  } rd_track_t;

  // OR of the indices of all set bits; exact for a legal single-hot input.
  function automatic logic [L1B_SLOT_WID-1:0] onehot2idx(input logic [L1B_ONE_BANK_NUM-1:0] oh);
    logic [L1B_SLOT_WID-1:0] idx;
    idx = '0;
    for (int i = 0; i < L1B_ONE_BANK_NUM; i++) begin
      if (oh[i]) idx = idx | L1B_SLOT_WID'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/l1b_rsp_fifo.sv
// rtl/l1b_rsp_fifo.sv - response FIFO with registered head entry and overflow pulse
module l1b_rsp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     head_vld,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          head_vld_q, head_vld_d;
  logic [DW-1:0] head_data_q, head_data_d;
  logic          do_push, do_pop;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign count_nxt = cnt_d;
  assign head_vld  = head_vld_q;
  assign head_data = head_data_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop & head_vld_q;
    do_push  = push & (~full | do_pop);
    ovf      = push & full & ~do_pop;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d       = cnt_q + CW'(do_push) - CW'(do_pop);
    head_vld_d  = (cnt_d != '0);
    head_data_d = head_vld_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
    end
  end

endmodule

// File: rtl/l1b_cache_rd_data_return.sv
// rtl/l1b_cache_rd_data_return.sv - tracks bank reads through RAM latency, selects words, queues LSU responses
module l1b_cache_rd_data_return
  import l1b_cache_pkg::*;
#(
  parameter int LB_ONE_BANK_NUM = L1B_ONE_BANK_NUM,
  parameter int RAM_DW          = 128,
  parameter int RAM_RD_LAT      = 1,
  parameter int RSP_FIFO_DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  l1b_op_norm_parallel_mode,
  input  logic [2*LB_ONE_BANK_NUM-1:0]          l1b_bank0_ram_cs,
  input  logic                                  l1b_bank0_ram_wr_en,
  input  logic [2*LB_ONE_BANK_NUM-1:0]          l1b_bank1_ram_cs,
  input  logic                                  l1b_bank1_ram_wr_en,
  input  logic [2*LB_ONE_BANK_NUM*RAM_DW-1:0]   l1b_bank0_ram_rdata,
  input  logic [2*LB_ONE_BANK_NUM*RAM_DW-1:0]   l1b_bank1_ram_rdata,
  output logic                                  l1b_rd_ready,
  output logic                                  l1b_rsp_valid,
  input  logic                                  l1b_rsp_ready,
  output logic [1:0]                            l1b_rsp_bank_vld,
  output logic [4*RAM_DW-1:0]                   l1b_rsp_data,
  output logic                                  l1b_rd_ovf
);
  localparam int N  = LB_ONE_BANK_NUM;
  localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int DW = 2 + 4 * RAM_DW;

  rd_track_t         trk_in, cap;
  rd_track_t         trk_q [RAM_RD_LAT];
  rd_track_t         trk_d [RAM_RD_LAT];
  logic              rd0, rd1;
  logic [N-1:0]      oh0, oh1;
  logic [RAM_DW-1:0] lo0, hi0, lo1, hi1;
  logic              push, head_vld, fifo_ovf, fifo_full, fifo_empty;
  logic [DW-1:0]     push_data, head_data;
  logic [CW-1:0]     fifo_count, fifo_count_nxt;
  logic [OW-1:0]     occ_d;
  logic              rd_ready_d, rd_ready_q, ovf_d, ovf_q;
  logic              unused_fifo;

  always_comb begin
    rd0 = (|l1b_bank0_ram_cs) & ~l1b_bank0_ram_wr_en & ~l1b_op_norm_parallel_mode;
    rd1 = (|l1b_bank1_ram_cs) & ~l1b_bank1_ram_wr_en & ~l1b_op_norm_parallel_mode;
    trk_in.vld      = rd0 | rd1;
    trk_in.bank_vld = {rd1, rd0};
    trk_in.slot0    = (|l1b_bank0_ram_cs[N-1:0]) ? onehot2idx(l1b_bank0_ram_cs[N-1:0])
                                                 : onehot2idx(l1b_bank0_ram_cs[2*N-1:N]);
    trk_in.slot1    = (|l1b_bank1_ram_cs[N-1:0]) ? onehot2idx(l1b_bank1_ram_cs[N-1:0])
                                                 : onehot2idx(l1b_bank1_ram_cs[2*N-1:N]);
    trk_d[0] = trk_in;
    for (int i = 1; i < RAM_RD_LAT; i++) trk_d[i] = trk_q[i-1];
  end

  // Last pipeline stage lines up with the cycle the RAM rdata is valid.
  always_comb begin
    cap = trk_q[RAM_RD_LAT-1];
    oh0 = '0;
    oh1 = '0;
    oh0[cap.slot0] = cap.bank_vld[0];
    oh1[cap.slot1] = cap.bank_vld[1];
    lo0 = '0;
    hi0 = '0;
    lo1 = '0;
    hi1 = '0;
    for (int i = 0; i < N; i++) begin
      lo0 = lo0 | (l1b_bank0_ram_rdata[i*RAM_DW +: RAM_DW]     & {RAM_DW{oh0[i]}});
      hi0 = hi0 | (l1b_bank0_ram_rdata[(i+N)*RAM_DW +: RAM_DW] & {RAM_DW{oh0[i]}});
      lo1 = lo1 | (l1b_bank1_ram_rdata[i*RAM_DW +: RAM_DW]     & {RAM_DW{oh1[i]}});
      hi1 = hi1 | (l1b_bank1_ram_rdata[(i+N)*RAM_DW +: RAM_DW] & {RAM_DW{oh1[i]}});
    end
    push      = cap.vld;
    push_data = {cap.bank_vld, hi1, lo1, hi0, lo0};
  end

  l1b_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (l1b_rsp_ready),
    .head_vld  (head_vld),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .ovf       (fifo_ovf)
  );

  assign unused_fifo = ^{fifo_full, fifo_empty, fifo_count};

  // One entry of slack absorbs a read already sitting in the upstream cs register.
  always_comb begin
    occ_d = OW'(fifo_count_nxt);
    for (int i = 0; i < RAM_RD_LAT; i++) occ_d = occ_d + OW'(trk_d[i].vld);
    rd_ready_d = (occ_d <= OW'(RSP_FIFO_DEPTH - 2));
    ovf_d      = ovf_q | fifo_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_RD_LAT; i++) trk_q[i] <= '0;
      rd_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      trk_q      <= trk_d;
      rd_ready_q <= rd_ready_d;
      ovf_q      <= ovf_d;
    end
  end

  assign l1b_rd_ready     = rd_ready_q;
  assign l1b_rd_ovf       = ovf_q;
  assign l1b_rsp_valid    = head_vld;
  assign l1b_rsp_bank_vld = head_data[DW-1 -: 2];
  assign l1b_rsp_data     = head_data[4*RAM_DW-1:0];

endmodule

// File: tb/tb_l1b_cache_rd_data_return.sv
// tb/tb_l1b_cache_rd_data_return.sv - scoreboard bench for the L1 buffer read-return path
module tb_l1b_cache_rd_data_return;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pm = 1'b0;
  logic [15:0]   cs0 = '0, cs1 = '0;
  logic          w0 = 1'b0, w1 = 1'b0;
  logic [2047:0] rdata0 = '0, rdata1 = '0;
  logic          rd_ready, rsp_valid, ovf;
  logic          rsp_ready = 1'b0;
  logic [1:0]    bank_vld;
  logic [511:0]  data;
  logic [31:0]   cyc_q = '0;
  logic [513:0]  sb[$];
  logic [513:0]  got;
  int            total = 0;
  int            bad = 0;

  l1b_cache_rd_data_return dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .l1b_op_norm_parallel_mode (pm),
    .l1b_bank0_ram_cs          (cs0),
    .l1b_bank0_ram_wr_en       (w0),
    .l1b_bank1_ram_cs          (cs1),
    .l1b_bank1_ram_wr_en       (w1),
    .l1b_bank0_ram_rdata       (rdata0),
    .l1b_bank1_ram_rdata       (rdata1),
    .l1b_rd_ready              (rd_ready),
    .l1b_rsp_valid             (rsp_valid),
    .l1b_rsp_ready             (rsp_ready),
    .l1b_rsp_bank_vld          (bank_vld),
    .l1b_rsp_data              (data),
    .l1b_rd_ovf                (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input int b, input int i, input logic [31:0] k);
    return {k, 32'(i), 32'(b), 32'hC0DE_0000 ^ k};
  endfunction

  // RAM model: one-cycle latency, every RAM word tagged with bank, index and cycle.
  always @(posedge clk) begin
    cyc_q <= cyc_q + 1;
    for (int i = 0; i < 16; i++) begin
      rdata0[i*128 +: 128] <= pat(0, i, cyc_q);
      rdata1[i*128 +: 128] <= pat(1, i, cyc_q);
    end
  end

  function automatic int slot_of(input logic [15:0] c);
    for (int j = 0; j < 16; j++) if (c[j]) return j % 8;
    return 0;
  endfunction

  function automatic logic [513:0] exp_rsp(input logic [15:0] c0, input logic [15:0] c1,
                                           input logic a0, input logic a1, input logic p,
                                           input logic [31:0] k);
    logic [255:0] h0, h1;
    logic [1:0]   bv;
    int           s;
    h0 = '0;
    h1 = '0;
    bv = 2'b00;
    if (|c0 && !a0 && !p) begin
      s = slot_of(c0);
      h0 = {pat(0, s + 8, k), pat(0, s, k)};
      bv[0] = 1'b1;
    end
    if (|c1 && !a1 && !p) begin
      s = slot_of(c1);
      h1 = {pat(1, s + 8, k), pat(1, s, k)};
      bv[1] = 1'b1;
    end
    return {bv, h1, h0};
  endfunction

  task automatic chk(input string tag, input logic [513:0] obs, input logic [513:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] c0, input logic [15:0] c1, input logic a0,
                    input logic a1, input logic p, input bit keep);
    logic [513:0] e;
    cs0 = c0;
    cs1 = c1;
    w0  = a0;
    w1  = a1;
    pm  = p;
    e = exp_rsp(c0, c1, a0, a1, p, cyc_q);
    if (keep && e[513:512] != 2'b00) sb.push_back(e);
    step();
    cs0 = '0;
    cs1 = '0;
    w0  = 1'b0;
    w1  = 1'b0;
    pm  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    step();
    chk(tag, 514'(sb.size()), 514'd0);
    chk({tag, "_valid_low"}, 514'(rsp_valid), 514'd0);
  endtask

  // Monitor pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      got = {bank_vld, data};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL unexpected_rsp observed=%0h expected=none", got);
      end else begin
        assert (got === sb[0]) else begin
          bad++;
          $error("FAIL rsp_data observed=%0h expected=%0h", got, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", 514'(rsp_valid), 514'd0);
    chk("rst_bank_vld", 514'(bank_vld), 514'd0);
    chk("rst_data", 514'(data), 514'd0);
    chk("rst_ovf", 514'(ovf), 514'd0);
    chk("rst_rd_ready", 514'(rd_ready), 514'd1);
    rst_n = 1'b1;
    repeat (2) step();

    // Single read: latency and lower-half placement
    rsp_ready = 1'b1;
    rd(16'h0404, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_early_valid", 514'(rsp_valid), 514'd0);
    @(negedge clk);
    chk("lat_valid", 514'(rsp_valid), 514'd1);
    chk("single_bank_vld", 514'(bank_vld), 514'd1);
    chk("single_upper_zero", 514'(data[511:256]), 514'd0);
    step();
    drain("single_drain");

    // Double-channel and mixed write/read
    rd(16'h8080, 16'h8080, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("double_drain");
    rd(16'h0010, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mixed_bank_vld", 514'(bank_vld), 514'd2);
    step();
    for (int k = 0; k < 6; k++) begin
      rd(16'd1 << $urandom_range(0, 15), 16'd1 << $urandom_range(0, 15), 1'b0,
         1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    drain("rand_drain");

    // Back-pressure: capacity drops after three outstanding reads
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_rd_ready_%0d", i), 514'(rd_ready), (i < 3) ? 514'd1 : 514'd0);
      rd(16'd1 << (i * 3), 16'd1 << (15 - i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    repeat (2) step();
    chk("bp_rd_ready_low", 514'(rd_ready), 514'd0);
    chk("bp_valid", 514'(rsp_valid), 514'd1);
    @(negedge clk);
    chk("bp_hold_a", {bank_vld, data}, sb[0]);
    @(negedge clk);
    chk("bp_hold_b", {bank_vld, data}, sb[0]);
    step();
    drain("bp_drain");
    chk("bp_no_ovf", 514'(ovf), 514'd0);
    chk("bp_rd_ready_back", 514'(rd_ready), 514'd1);

    // Overflow: the fifth capture is dropped
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(16'd1 << (i + 1), 16'd0, 1'b0, 1'b0, 1'b0, (i < 4));
    end
    chk("ovf_before", 514'(ovf), 514'd0);
    step();
    chk("ovf_after", 514'(ovf), 514'd1);
    drain("ovf_drain");
    chk("ovf_sticky", 514'(ovf), 514'd1);

    // Reset with two queued and one in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd(16'd1 << (i + 8), 16'd1 << i, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 514'(rsp_valid), 514'd0);
    chk("mid_rst_bank_vld", 514'(bank_vld), 514'd0);
    chk("mid_rst_data", 514'(data), 514'd0);
    chk("mid_rst_ovf", 514'(ovf), 514'd0);
    chk("mid_rst_rd_ready", 514'(rd_ready), 514'd1);
    repeat (2) step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) step();
    chk("post_rst_no_stale", 514'(rsp_valid), 514'd0);

    // Filtering: writes and parallel-mode reads produce nothing
    rd(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("filt_wr_ready", 514'(rd_ready), 514'd1);
    rd(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("filt_wr0_ready", 514'(rd_ready), 514'd1);
    rd(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("filt_pm_ready", 514'(rd_ready), 514'd1);
    repeat (4) step();
    chk("filt_valid", 514'(rsp_valid), 514'd0);
    chk("filt_rd_ready", 514'(rd_ready), 514'd1);
    chk("final_sb_empty", 514'(sb.size()), 514'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
